// File: rtl/dmem_console_pkg.sv
// Shared types and constants for the data-memory slave with MMIO console.
// Status word layout used by console reads lives here so TB and RTL agree.
package dmem_console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1122_3344;

  typedef struct packed {
    logic [7:0] count;
    logic       full;
    logic       empty;
  } console_status_t;

  function automatic logic [31:0] pack_status(input console_status_t s);
    return {16'b0, s.count, 6'b0, s.full, s.empty};
  endfunction

endpackage

// File: rtl/dmem_console_fifo.sv
// Console TX FIFO: push/pop with a same-cycle push accepted on full if a pop frees a slot.
// Head reads as zero while empty so the sink never sees stale bytes.
module console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             push_ok,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; gating on reset drops a push in the reset-assert cycle.
  always_ff @(posedge clk) begin
    if (reset && push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_console.sv
// Word RAM with byte-lane writes, 1-cycle registered read, and one MMIO console register.
// Optional DMEM_CONSOLE_LOG_EN adds simulation-only echo of console bytes.
module dmem_console
   import dmem_console_pkg::*;
#(
   parameter int          DEPTH        = 1024,
   parameter int          TX_DEPTH     = 16,
   parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_write_in,
   input  logic [31:0] dmem_write_addr_in,
   input  logic [31:0] dmem_write_data_in,
   input  logic [7:0]  dmem_write_mask_in,
   input  logic        dmem_read_in,
   input  logic [31:0] dmem_read_addr_in,
   output logic [31:0] dmem_read_data_out,
   output logic        tx_valid_out,
   output logic [7:0]  tx_data_out,
   input  logic        tx_ready_in,
   output logic [15:0] drop_count_out,
   input  logic        debugen_in
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic [31:0]     mem [DEPTH];
   logic [IW-1:0]   widx;
   logic [IW-1:0]   ridx;
   logic            wr_console;
   logic            rd_console;
   logic            ram_we;
   logic            push;
   logic            pop;
   logic            push_ok;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   console_status_t status;
   logic            unused_bits;

   assign widx         = dmem_write_addr_in[IW+1:2];
   assign ridx         = dmem_read_addr_in[IW+1:2];
   assign wr_console   = (dmem_write_addr_in == CONSOLE_ADDR);
   assign rd_console   = (dmem_read_addr_in == CONSOLE_ADDR);
   assign ram_we       = dmem_write_in && !wr_console;
   assign push         = dmem_write_in && wr_console && dmem_write_mask_in[0];
   assign pop          = tx_valid_out && tx_ready_in;
   assign tx_valid_out = !fifo_empty;

   assign status = '{count: 8'(fifo_count), full: fifo_full, empty: fifo_empty};

   console_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (dmem_write_data_in[7:0]),
      .pop       (pop),
      .push_ok   (push_ok),
      .head      (tx_data_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // RAM keeps its contents across reset; reset only suppresses the write.
   always_ff @(posedge clk) begin
      if (reset && ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_write_mask_in[i]) mem[widx][8*i +: 8] <= dmem_write_data_in[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem_read_data_out <= '0;
      end else if (dmem_read_in) begin
         dmem_read_data_out <= rd_console ? pack_status(status) : mem[ridx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count_out <= '0;
      end else if (push && !push_ok && (drop_count_out != 16'hFFFF)) begin
         drop_count_out <= drop_count_out + 16'd1;
      end
   end

   assign unused_bits = ^{dmem_write_mask_in[7:4], debugen_in};

`ifdef DMEM_CONSOLE_LOG_EN
   always @(posedge clk) begin
      if (reset) begin
         if (push_ok)
            $write("%c", dmem_write_data_in[7:0]);
         if (debugen_in && ram_we)
            $display("dmem wr idx=%0d data=%08h mask=%01h", widx, dmem_write_data_in, dmem_write_mask_in[3:0]);
      end
   end
`endif

endmodule

// File: tb/tb_dmem_console.sv
// Scoreboard bench for dmem_console: expected reads and console bytes are queued at issue
// and checked by independent monitors when the DUT presents them.
module tb_dmem_console;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_write_in = 1'b0;
  logic [31:0] dmem_write_addr_in = '0;
  logic [31:0] dmem_write_data_in = '0;
  logic [7:0]  dmem_write_mask_in = '0;
  logic        dmem_read_in = 1'b0;
  logic [31:0] dmem_read_addr_in = '0;
  logic [31:0] dmem_read_data_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in = 1'b0;
  logic [15:0] drop_count_out;
  logic        debugen_in = 1'b0;

  localparam logic [31:0] CADDR = 32'h1122_3344;

  int passes = 0;
  int total  = 0;

  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic [7:0]  tx_exp[$];

  dmem_console dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_write_in      (dmem_write_in),
    .dmem_write_addr_in (dmem_write_addr_in),
    .dmem_write_data_in (dmem_write_data_in),
    .dmem_write_mask_in (dmem_write_mask_in),
    .dmem_read_in       (dmem_read_in),
    .dmem_read_addr_in  (dmem_read_addr_in),
    .dmem_read_data_out (dmem_read_data_out),
    .tx_valid_out       (tx_valid_out),
    .tx_data_out        (tx_data_out),
    .tx_ready_in        (tx_ready_in),
    .drop_count_out     (drop_count_out),
    .debugen_in         (debugen_in)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Read monitor: data is due #1 after the edge that sampled the strobe.
  always @(posedge clk) begin
    if (reset === 1'b1 && dmem_read_in === 1'b1) begin
      #1;
      if (rd_exp.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: got %08h expected no read", dmem_read_data_out);
      end else begin
        chk(rd_name.pop_front(), dmem_read_data_out, rd_exp.pop_front());
      end
    end
  end

  // Console monitor: each handshake must deliver the oldest expected byte.
  always @(posedge clk) begin
    if (reset === 1'b1 && tx_valid_out === 1'b1 && tx_ready_in === 1'b1) begin
      if (tx_exp.size() == 0) begin
        total++;
        $display("FAIL tx_unexpected: got %02h expected no byte", tx_data_out);
      end else begin
        chk("tx_byte", {24'b0, tx_data_out}, {24'b0, tx_exp.pop_front()});
      end
    end
  end

  task automatic op(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                    input logic [7:0] wm, input logic re, input logic [31:0] ra,
                    input logic [31:0] rexp, input string nm);
    dmem_write_in      = we;
    dmem_write_addr_in = wa;
    dmem_write_data_in = wd;
    dmem_write_mask_in = wm;
    dmem_read_in       = re;
    dmem_read_addr_in  = ra;
    if (re) begin
      rd_exp.push_back(rexp);
      rd_name.push_back(nm);
    end
    @(negedge clk);
    dmem_write_in = 1'b0;
    dmem_read_in  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    op(1'b1, a, d, m, 1'b0, 32'h0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    op(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, a, e, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (2) @(negedge clk);
    chk("rst_rdata", dmem_read_data_out, 32'h0);
    chk("rst_txvalid", {31'b0, tx_valid_out}, 32'h0);
    chk("rst_txdata", {24'b0, tx_data_out}, 32'h0);
    chk("rst_drop", {16'b0, drop_count_out}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Byte lanes and mask handling
    tx_ready_in = 1'b1;
    wr(32'h100, 32'hAABB_CCDD, 8'h0F);
    wr(32'h100, 32'h0000_0011, 8'h01);
    rd(32'h100, 32'hAABB_CC11, "lane0_merge");
    wr(32'h100, 32'hFFFF_FFFF, 8'h00);
    wr(32'h100, 32'hFFFF_FFFF, 8'hF0);
    rd(32'h100, 32'hAABB_CC11, "mask_noop");
    wr(32'h100, 32'h0055_0000, 8'h04);
    rd(32'h100, 32'hAA55_CC11, "lane2_merge");

    // Read-before-write on the same index
    wr(32'h40, 32'h0, 8'h0F);
    op(1'b1, 32'h40, 32'h5, 8'h0F, 1'b1, 32'h40, 32'h0, "rbw_old");
    rd(32'h40, 32'h5, "rbw_new");

    // Aliasing and console address exclusion
    wr(32'h1008, 32'hCAFE_F00D, 8'h0F);
    rd(32'h8, 32'hCAFE_F00D, "alias");
    wr(32'h344, 32'h1234_5678, 8'h0F);
    tx_exp.push_back(8'h99);
    wr(CADDR, 32'h9999_9999, 8'h01);
    rd(32'h344, 32'h1234_5678, "console_no_ram");
    repeat (3) @(negedge clk);

    // Fill FIFO with sink stalled: 16 accepted, 2 dropped
    tx_ready_in = 1'b0;
    for (int k = 0; k < 18; k++) begin
      b = (k == 0) ? 8'h48 : (k == 1) ? 8'h69 : 8'(8'h30 + k - 2);
      if (k < 16) tx_exp.push_back(b);
      wr(CADDR, {24'h0, b}, 8'h01);
    end
    rd(CADDR, 32'h0000_1002, "status_full");
    chk("drop_after_fill", {16'b0, drop_count_out}, 32'd2);

    // Full FIFO: push and pop together both succeed
    tx_ready_in = 1'b1;
    tx_exp.push_back(8'h7A);
    wr(CADDR, 32'h7A, 8'h01);
    tx_ready_in = 1'b0;
    rd(CADDR, 32'h0000_1002, "status_full_pushpop");
    chk("drop_after_pushpop", {16'b0, drop_count_out}, 32'd2);

    tx_ready_in = 1'b1;
    for (int k = 0; k < 100 && tx_valid_out; k++) @(negedge clk);
    chk("drain_done", {31'b0, tx_valid_out}, 32'h0);
    chk("tx_queue_empty", tx_exp.size(), 32'h0);
    rd(CADDR, 32'h0000_0001, "status_empty");

    // Empty FIFO: pushed byte must not bypass
    dmem_write_in = 1'b1; dmem_write_addr_in = CADDR;
    dmem_write_data_in = 32'h55; dmem_write_mask_in = 8'h01;
    @(posedge clk); #1;
    tx_exp.push_back(8'h55);
    chk("nobypass_valid", {31'b0, tx_valid_out}, 32'h1);
    chk("nobypass_data", {24'b0, tx_data_out}, 32'h55);
    @(negedge clk);
    dmem_write_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("nobypass_drained", tx_exp.size(), 32'h0);

    // Reset mid-traffic
    tx_ready_in = 1'b0;
    wr(CADDR, 32'hA1, 8'h01);
    rd(32'h100, 32'hAA55_CC11, "pre_reset_rd");
    #2 reset = 1'b0;
    #1;
    chk("async_rdata", dmem_read_data_out, 32'h0);
    chk("async_txvalid", {31'b0, tx_valid_out}, 32'h0);
    chk("async_txdata", {24'b0, tx_data_out}, 32'h0);
    chk("async_drop", {16'b0, drop_count_out}, 32'h0);
    tx_exp.delete();
    @(negedge clk);
    wr(32'h100, 32'hFFFF_FFFF, 8'h0F);
    reset = 1'b1;
    @(negedge clk);
    rd(32'h100, 32'hAA55_CC11, "ram_survives_reset");
    rd(CADDR, 32'h0000_0001, "status_after_reset");

    repeat (3) @(negedge clk);
    chk("rd_queue_empty", rd_exp.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
